// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   state_t      : controller state encoding (IDLE, RUN, DONE)
//   OP_ADD/OP_SUB: values of the sel input
//   width_check  : true when WIDTH is a non-zero multiple of DIGIT
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Used at elaboration to reject parameter sets where the operand
  // cannot be split into whole digits.
  function automatic bit width_check(input int width, input int digit);
    if (digit < 1 || digit > width) return 1'b0;
    return (width % digit) == 0;
  endfunction

endpackage

// File: rtl/serial_addsub_digit.sv
// DIGIT-bit ripple-carry adder slice built from full-adder equations.
// Ports:
//   a, b      : digit operands (b already inverted by the caller for subtract)
//   cin       : carry into bit 0
//   s         : digit sum
//   cout      : carry out of the top bit
//   c_msb_in  : carry into the top bit (needed for the overflow flag)
module addsub_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  always_comb begin
    logic c;
    c        = cin;
    s        = '0;
    c_msb_in = cin;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb_in = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor. Processes a WIDTH-bit operand pair DIGIT
// bits per clock, least-significant digit first, behind a start/busy/done
// handshake.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   start     : request, sampled when ready=1
//   sel       : 0 = a+b, 1 = a-b (captured with start)
//   a, b      : operands (captured with start)
//   ready     : high in IDLE and DONE
//   busy      : high in RUN
//   done      : one-cycle pulse when the result is committed
//   sum       : registered result, held until the next commit
//   cout      : carry out of the MSB (subtract: 1 = no borrow)
//   ovf       : two's-complement overflow
//   zero      : sum == 0
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int  NCYC      = WIDTH / DIGIT;
  localparam int  CW        = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam bit  PARAMS_OK = width_check(WIDTH, DIGIT);

  generate
    if (!PARAMS_OK) begin : g_param_err
      $error("serial_addsub: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] d_s;
  logic             d_cout;
  logic             d_cmsb;
  logic             last;
  logic             is_sub;

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .cin      (carry),
    .s        (d_s),
    .cout     (d_cout),
    .c_msb_in (d_cmsb)
  );

  assign is_sub = (sel == OP_SUB);
  assign last   = (cnt == CW'(NCYC - 1));

  // Result fills from the top so that after NCYC digits the first (least
  // significant) digit has arrived at bit 0. Written as shift-then-overlay
  // so the DIGIT == WIDTH case needs no special slicing.
  always_comb begin
    res_next                  = res_sh >> DIGIT;
    res_next[WIDTH-1 -: DIGIT] = d_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
      ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtract is a + ~b + 1: invert b here, inject the +1 as carry-in.
            a_sh   <= a;
            b_sh   <= b ^ {WIDTH{is_sub}};
            carry  <= is_sub;
            cnt    <= '0;
            res_sh <= '0;
            busy   <= 1'b1;
            ready  <= 1'b0;
            state  <= ST_RUN;
          end else begin
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          carry  <= d_cout;
          res_sh <= res_next;
          cnt    <= cnt + CW'(1);
          if (last) begin
            sum   <= res_next;
            cout  <= d_cout;
            ovf   <= d_cmsb ^ d_cout;
            zero  <= (res_next == '0);
            done  <= 1'b1;
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= ST_DONE;
          end
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: four instances (DIGIT = 2, 1, 4, 8; WIDTH = 8)
// checked every cycle against a timeline/arithmetic model, plus directed
// literal expectations on the DIGIT=2 instance.
module tb_serial_addsub;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic       start_in [N];
  logic       sel_in   [N];
  logic [7:0] a_in     [N];
  logic [7:0] b_in     [N];
  logic       ready_o  [N];
  logic       busy_o   [N];
  logic       done_o   [N];
  logic [7:0] sum_o    [N];
  logic       cout_o   [N];
  logic       ovf_o    [N];
  logic       zero_o   [N];

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  function automatic int dig_of(input int i);
    case (i)
      0: return 2;
      1: return 1;
      2: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic int ncyc_of(input int i);
    return 8 / dig_of(i);
  endfunction

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      serial_addsub #(
        .WIDTH (8),
        .DIGIT ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8)
      ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start_in[g]),
        .sel   (sel_in[g]),
        .a     (a_in[g]),
        .b     (b_in[g]),
        .ready (ready_o[g]),
        .busy  (busy_o[g]),
        .done  (done_o[g]),
        .sum   (sum_o[g]),
        .cout  (cout_o[g]),
        .ovf   (ovf_o[g]),
        .zero  (zero_o[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the definition: integer sum/difference,
  // carry = unsigned overflow (add) or a >= b (sub), ovf = signed result
  // outside the 8-bit range.
  function automatic void ref_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 output logic [7:0] r, output bit c, output bit v, output bit z);
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s == 1'b0) begin
      ur = ua + ub;
      sr = sa + sb;
      c  = (ur > 255);
    end else begin
      ur = ua - ub;
      sr = sa - sb;
      c  = (ua >= ub);
    end
    r = 8'(ur & 255);
    v = (sr > 127) || (sr < -128);
    z = (r == 8'h00);
  endfunction

  // Model: an accepted request commits NCYC edges after the accept edge;
  // done is visible in the cycle after that edge.
  logic [7:0] m_sum  [N];
  bit         m_cout [N];
  bit         m_ovf  [N];
  bit         m_zero [N];
  bit         m_done [N];
  bit         m_pend [N];
  bit         m_ready[N];
  int         m_cedge[N];
  logic [7:0] p_sum  [N];
  bit         p_cout [N];
  bit         p_ovf  [N];
  bit         p_zero [N];
  int         edge_no = 0;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      bit commit;
      bit accept;
      if (rst) begin
        m_sum[i]   = 8'h00;
        m_cout[i]  = 1'b0;
        m_ovf[i]   = 1'b0;
        m_zero[i]  = 1'b0;
        m_done[i]  = 1'b0;
        m_pend[i]  = 1'b0;
        m_ready[i] = 1'b1;
      end else begin
        commit    = m_pend[i] && (edge_no == m_cedge[i]);
        accept    = m_ready[i] && (start_in[i] == 1'b1);
        m_done[i] = commit;
        if (commit) begin
          m_sum[i]  = p_sum[i];
          m_cout[i] = p_cout[i];
          m_ovf[i]  = p_ovf[i];
          m_zero[i] = p_zero[i];
          m_pend[i] = 1'b0;
        end
        if (accept) begin
          ref_op(a_in[i], b_in[i], sel_in[i], p_sum[i], p_cout[i], p_ovf[i], p_zero[i]);
          m_pend[i]  = 1'b1;
          m_cedge[i] = edge_no + ncyc_of(i);
        end
        m_ready[i] = !m_pend[i];
      end
    end
    edge_no++;
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("ready[%0d]", i), 32'(ready_o[i]), 32'(m_ready[i]));
        chk($sformatf("busy[%0d]", i),  32'(busy_o[i]),  32'(m_pend[i]));
        chk($sformatf("done[%0d]", i),  32'(done_o[i]),  32'(m_done[i]));
        chk($sformatf("sum[%0d]", i),   32'(sum_o[i]),   32'(m_sum[i]));
        chk($sformatf("cout[%0d]", i),  32'(cout_o[i]),  32'(m_cout[i]));
        chk($sformatf("ovf[%0d]", i),   32'(ovf_o[i]),   32'(m_ovf[i]));
        chk($sformatf("zero[%0d]", i),  32'(zero_o[i]),  32'(m_zero[i]));
      end
    end
  end

  // Directed op on instance 0; returns cycles from drive to done.
  task automatic op0(input logic [7:0] a, input logic [7:0] b, input logic s, output int lat);
    a_in[0] = a; b_in[0] = b; sel_in[0] = s; start_in[0] = 1'b1;
    @(negedge clk);
    start_in[0] = 1'b0;
    lat = 1;
    while (done_o[0] !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (done_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL op0_timeout: no done within %0d cycles, expected one", lat);
    end
  endtask

  task automatic sweep_drive(input int g, input int nops);
    int guard;
    int hold;
    for (int n = 0; n < nops; n++) begin
      guard = 0;
      while (ready_o[g] !== 1'b1 && guard < 40) begin
        a_in[g] = 8'($urandom);
        b_in[g] = 8'($urandom);
        sel_in[g] = 1'($urandom);
        @(negedge clk);
        guard++;
      end
      if (ready_o[g] !== 1'b1) begin
        errors++;
        $display("FAIL sweep_ready_timeout[%0d]: ready=%b, expected 1", g, ready_o[g]);
        return;
      end
      a_in[g] = 8'($urandom);
      b_in[g] = 8'($urandom);
      sel_in[g] = 1'($urandom);
      start_in[g] = 1'b1;
      @(negedge clk);
      hold = $urandom_range(0, 2);
      for (int h = 0; h < hold; h++) begin
        a_in[g] = 8'($urandom);
        b_in[g] = 8'($urandom);
        sel_in[g] = 1'($urandom);
        @(negedge clk);
      end
      start_in[g] = 1'b0;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int guard;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start_in[i] = 1'b0; sel_in[i] = 1'b0; a_in[i] = 8'h00; b_in[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    checking = 1'b1;
    chk("reset_ready", 32'(ready_o[0]), 32'd1);
    chk("reset_sum",   32'(sum_o[0]),   32'd0);
    rst = 1'b0;
    @(negedge clk);

    op0(8'h3C, 8'h15, 1'b0, lat);
    chk("add_latency", 32'(lat), 32'd5);
    chk("add_sum",  32'(sum_o[0]),  32'h51);
    chk("add_cout", 32'(cout_o[0]), 32'd0);
    chk("add_ovf",  32'(ovf_o[0]),  32'd0);
    chk("add_zero", 32'(zero_o[0]), 32'd0);

    op0(8'h5A, 8'h5A, 1'b1, lat);
    chk("subz_sum",  32'(sum_o[0]),  32'h00);
    chk("subz_cout", 32'(cout_o[0]), 32'd1);
    chk("subz_ovf",  32'(ovf_o[0]),  32'd0);
    chk("subz_zero", 32'(zero_o[0]), 32'd1);

    op0(8'h7F, 8'h01, 1'b0, lat);
    chk("ovf_sum",  32'(sum_o[0]),  32'h80);
    chk("ovf_ovf",  32'(ovf_o[0]),  32'd1);
    chk("ovf_cout", 32'(cout_o[0]), 32'd0);

    op0(8'h00, 8'h01, 1'b1, lat);
    chk("borrow_sum",  32'(sum_o[0]),  32'hFF);
    chk("borrow_cout", 32'(cout_o[0]), 32'd0);
    chk("borrow_ovf",  32'(ovf_o[0]),  32'd0);

    // start held through RUN with changing operands; the second request
    // is taken on the edge that ends the done cycle.
    @(negedge clk);
    a_in[0] = 8'h21; b_in[0] = 8'h12; sel_in[0] = 1'b0; start_in[0] = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (done_o[0] !== 1'b1) begin
        a_in[0] = 8'($urandom); b_in[0] = 8'($urandom); sel_in[0] = 1'($urandom);
      end
    end while (done_o[0] !== 1'b1 && guard < 20);
    chk("hs_first_sum", 32'(sum_o[0]), 32'h33);
    a_in[0] = 8'h10; b_in[0] = 8'h20; sel_in[0] = 1'b0;
    @(negedge clk);
    start_in[0] = 1'b0;
    chk("hs_second_busy", 32'(busy_o[0]), 32'd1);
    guard = 0;
    while (done_o[0] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("hs_second_sum", 32'(sum_o[0]), 32'h30);
    repeat (6) @(negedge clk);

    // Reset during the second RUN cycle abandons the operation.
    a_in[0] = 8'h44; b_in[0] = 8'h11; sel_in[0] = 1'b1; start_in[0] = 1'b1;
    @(negedge clk);
    start_in[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstrun_ready", 32'(ready_o[0]), 32'd1);
    chk("rstrun_busy",  32'(busy_o[0]),  32'd0);
    chk("rstrun_done",  32'(done_o[0]),  32'd0);
    chk("rstrun_sum",   32'(sum_o[0]),   32'd0);
    chk("rstrun_cout",  32'(cout_o[0]),  32'd0);
    guard = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_o[0] === 1'b1) guard++;
    end
    chk("rstrun_no_done", 32'(guard), 32'd0);

    fork
      sweep_drive(0, 1000);
      sweep_drive(1, 1000);
      sweep_drive(2, 1000);
      sweep_drive(3, 1000);
    join
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair DIGIT bits per clock, least-significant digit first.
- It is the sequential successor to the team's 1-bit add/sub full-adder cell (B inverted by the op select, carry-in driven by op).
- It trades latency for area in the ALU datapath, using a start/busy/done handshake.
- It produces the result plus carry, signed-overflow and zero flags.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 2, bits processed per cycle (1..WIDTH). NCYC = WIDTH/DIGIT is the number of processing cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- sel  input  1  0 = A+B, 1 = A-B; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- ready  output  1  high in IDLE and DONE (start accepted).
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse; result and flags valid from this cycle until the next accepted start.
- sum  output  WIDTH  result, registered.
- cout  output  1  carry out of the MSB. For subtract, 1 = no borrow (A >= B unsigned).
- ovf  output  1  two's-complement overflow = carry into MSB XOR carry out of MSB.
- zero  output  1  sum == 0.

Behaviour:
- Reset (clk edge with rst=1) takes priority over everything:
  - state=IDLE
  - sum=0, cout=0, ovf=0, zero=0, done=0, busy=0, ready=1
  - internal shift registers, digit counter and carry cleared.
  - Reset mid-RUN abandons the operation; no done is produced.
- States are IDLE, RUN and DONE.
  - IDLE/DONE with start=1: on the edge, capture a, b and sel. Load carry register = sel; B is stored as b XOR {WIDTH{sel}}. Counter=0, go to RUN.
  - DONE with start=0: the DONE state lasts one cycle, then IDLE. Outputs hold their values.
  - RUN: on each edge, add digit [DIGIT-1:0] of the A/B shift registers plus the carry register. Shift the sum digit into the result register from the top. Update the carry, shift A/B right by DIGIT, and increment the counter.
  - RUN, on the edge where counter==NCYC-1: commit sum, cout, ovf and zero from the final digit; go to DONE; done=1 in the following cycle.
- start while in RUN is ignored; there is no queue.
- Latency:
  - The start-accept edge is edge 0.
  - Digits are processed on edges 1..NCYC.
  - done is high in the cycle after edge NCYC.
  - A new start is accepted at the earliest on the edge that ends the done cycle (back-to-back issue). That edge clears done and enters RUN.
- Arithmetic:
  - Modulo 2^WIDTH.
  - ovf uses the carry into bit WIDTH-1, taken from inside the final digit.
  - DIGIT=WIDTH is legal: NCYC=1.
  - Changes on a, b and sel outside the accept edge have no effect.
- Outputs change only at start-accept (no change), commit (new values) and reset. sum, cout, ovf and zero are not cleared by a new start; they are overwritten at commit.

Decomposition:
- A shared package holds:
  - the state encoding (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2)
  - OP_ADD=1'b0 and OP_SUB=1'b1
  - a width-check constant function asserting WIDTH % DIGIT == 0.
- One combinational sub-module, addsub_digit, is natural. It is a DIGIT-bit ripple adder with ports a, b, cin, s, cout and c_msb_in (the carry into its top bit). It is built from the same full-adder equations.

Test Plan (WIDTH=8, DIGIT=2 unless noted):
- Add: a=8'h3C, b=8'h15, sel=0, start -> busy for 4 cycles; done 5 cycles after accept; sum=8'h51, cout=0, ovf=0, zero=0.
- Sub/zero: a=8'h5A, b=8'h5A, sel=1 -> sum=8'h00, cout=1, ovf=0, zero=1.
- Overflow/borrow:
  - a=8'h7F, b=8'h01, sel=0 -> sum=8'h80, ovf=1, cout=0.
  - a=8'h00, b=8'h01, sel=1 -> sum=8'hFF, cout=0, ovf=0.
- Handshake: start held high through RUN with changing a/b -> only the first operands are used; the second start is accepted on the edge ending the done cycle; result is correct, with no extra done pulse.
- Reset mid-RUN: rst=1 at cycle 2 of RUN -> next cycle has ready=1, busy=0, done=0 and all outputs 0; no done follows.
- Parameter sweep: DIGIT=1, 4 and 8 with random a/b/sel (1000 ops each) -> sum, cout and ovf match the reference model; done latency = WIDTH/DIGIT+1.
